axis_traffic_gen: RTL and testbench
===================================

// Module: axis_traffic_gen
// PURPOSE
//  Parametrised AXI-Stream traffic endpoint for the axis_mesh NoC.
//  Master side: NUM_PACKETS multi-flit packets of LFSR data, destinations rotated round-robin.
//  Slave side: sinks and counts received packets and flags length errors.
//  Raises DONE when sending is finished and EXPECT_RX packets have arrived; sits on one mesh node.
// PARAMETERS
//  TDATAW        32      data width; must be >= LFSR_DW
//  TDESTW        4       tdest width
//  LFSR_DW       8       LFSR width
//  LFSR_DEFAULT  8'hA5   seed loaded on START; 0 is replaced by 1
//  LFSR_TAPS     8'hB8   Galois feedback mask
//  NUM_PACKETS   16      packets sent per run (>=1)
//  PKT_LEN       4       flits per packet (>=1)
//  NUM_DESTS     2       destinations in rotation (>=1)
//  DEST_BASE     1       first tdest; flit tdest = DEST_BASE + dest_idx
//  EXPECT_RX     16      packets that must be received before DONE (0 allowed)
// PORTS
//  CLK            in   1       clock
//  RST_N          in   1       asynchronous active-low reset
//  START          in   1       one-cycle run request
//  BUSY           out  1       high in SEND or WAIT_RX
//  DONE           out  1       high in DONE state
//  TX_COUNT       out  16      packets fully sent (saturating)
//  RX_COUNT       out  16      packets received, counted by TLAST beats (saturating)
//  RX_ERR         out  1       sticky: a received packet's length != PKT_LEN
//  AXIS_M_TVALID/TREADY/TDATA[TDATAW]/TLAST/TDEST[TDESTW]   out/in/out/out/out   transmit stream
//  AXIS_S_TVALID/TREADY/TDATA[TDATAW]/TLAST/TDEST[TDESTW]   in/out/in/in/in      receive stream
// BEHAVIOUR
//  Reset (async, immediate): state IDLE; all outputs 0, including AXIS_S_TREADY.
//   LFSR = LFSR_DEFAULT; all counters 0.
//  FSM states and transitions:
//   IDLE: on START -> SEND; clear TX/RX counters, RX_ERR, flit_idx, dest_idx; load seed.
//   SEND: leave after the TLAST beat of packet NUM_PACKETS-1 is accepted.
//    -> DONE if RX_COUNT (including a same-cycle RX TLAST) >= EXPECT_RX, else -> WAIT_RX.
//   WAIT_RX: -> DONE when RX_COUNT >= EXPECT_RX.
//   DONE: START -> SEND with the same clearing as from IDLE.
//  START is ignored in SEND and WAIT_RX.
//  TX (registered outputs, zero-bubble):
//   AXIS_M_TVALID = 1 throughout SEND, including the first cycle after START.
//   TDATA = zero-extended LFSR. TLAST = (flit_idx == PKT_LEN-1).
//   TDEST = DEST_BASE + dest_idx, truncated to TDESTW bits.
//   A beat is accepted when TVALID && TREADY. On each accepted beat:
//    LFSR steps: lsb ? (l>>1)^TAPS : l>>1.
//    flit_idx increments and wraps to 0 after TLAST.
//    After TLAST, dest_idx increments (wraps at NUM_DESTS-1) and TX_COUNT++.
//   While TVALID && !TREADY, TDATA/TLAST/TDEST are held stable.
//   TVALID drops the cycle after the final beat is accepted.
//  RX:
//   AXIS_S_TREADY = 1 from the first CLK edge after reset release, in every state, including IDLE.
//   rx_flit counts accepted beats. On a TLAST beat:
//    RX_COUNT++.
//    RX_ERR set if rx_flit+1 != PKT_LEN.
//    rx_flit reset to 0.
//   RX_COUNT, RX_ERR and rx_flit are cleared only on a run start (START in IDLE/DONE), not otherwise.
//   RX TDATA and TDEST are not checked.
//  Simultaneous events: a TX final beat and an RX TLAST in the same cycle count both.
//  All counters saturate at 16'hFFFF.
//  Reset mid-run: returns to IDLE. A partial packet is abandoned and is not resumed.
// STRUCTURE
//  traffic_gen_pkg: state_t enum {IDLE, SEND, WAIT_RX, DONE}; function lfsr_next(l, taps).
//  One sub-module: lfsr_galois (params DW, TAPS; ports CLK, RST_N, load, seed, step, q).
//  Top holds the FSM, TX/RX counters and the output registers.
// TESTING
//  1. Defaults, M_TREADY=1, start: TDATA sequence 0xA5, 0xEA, 0x75, 0x82.
//     TLAST on the 4th beat; TDEST 1,1,1,1 then 2,2,2,2.
//  2. Backpressure: TREADY low for 3 cycles mid-packet.
//     -> TVALID/TDATA/TLAST/TDEST stable; no lost or duplicated beats; 64 beats total.
//  3. Loopback M->S, EXPECT_RX=16: DONE asserts with TX_COUNT=16, RX_COUNT=16, RX_ERR=0.
//     BUSY is low in DONE.
//  4. Inject a 3-flit packet (TLAST on 3rd beat) on the S side.
//     -> RX_ERR=1 and stays 1 until the next START.
//  5. EXPECT_RX=16 but only 15 packets returned: FSM holds WAIT_RX, BUSY=1, DONE=0.
//     The 16th packet -> DONE.
//  6. Assert RST_N=0 mid-packet: all outputs 0 immediately.
//     START after release restarts at 0xA5 with TX_COUNT=0.

Source files
------------

// File: rtl/traffic_gen_pkg.sv
// Shared types and helpers for the AXI-Stream traffic endpoint.
package traffic_gen_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_RX,
        DONE
    } state_t;

    // Galois step; callers truncate to their own width.
    function automatic logic [31:0] lfsr_next(input logic [31:0] l, input logic [31:0] taps);
        return l[0] ? ((l >> 1) ^ taps) : (l >> 1);
    endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Galois LFSR with synchronous seed load and per-beat step enable.
module lfsr_galois
    import traffic_gen_pkg::*;
#(
    parameter int          DW      = 8,
    parameter logic [31:0] TAPS    = 32'hB8,
    parameter logic [31:0] RST_VAL = 32'hA5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [DW-1:0] seed,
    input  logic          step,
    output logic [DW-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_VAL[DW-1:0];
        end else if (load) begin
            // An all-zero seed would lock the register up.
            q <= (seed == '0) ? DW'(1) : seed;
        end else if (step) begin
            q <= DW'(lfsr_next(32'(q), TAPS));
        end
    end

endmodule

// File: rtl/axis_traffic_gen.sv
// AXI-Stream traffic endpoint: sends LFSR packets round-robin over destinations,
// sinks and counts received packets, and reports completion.
//
//  state   | meaning
//  IDLE    | after reset, waiting for start
//  SEND    | transmitting NUM_PACKETS packets
//  WAIT_RX | transmit finished, waiting for EXPECT_RX packets
//  DONE    | run complete, start re-arms
module axis_traffic_gen
    import traffic_gen_pkg::*;
#(
    parameter int          TDATAW       = 32,
    parameter int          TDESTW       = 4,
    parameter int          LFSR_DW      = 8,
    parameter logic [31:0] LFSR_DEFAULT = 32'hA5,
    parameter logic [31:0] LFSR_TAPS    = 32'hB8,
    parameter int          NUM_PACKETS  = 16,
    parameter int          PKT_LEN      = 4,
    parameter int          NUM_DESTS    = 2,
    parameter int          DEST_BASE    = 1,
    parameter int          EXPECT_RX    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [15:0]       tx_count,
    output logic [15:0]       rx_count,
    output logic              rx_err,
    output logic              axis_m_tvalid,
    input  logic              axis_m_tready,
    output logic [TDATAW-1:0] axis_m_tdata,
    output logic              axis_m_tlast,
    output logic [TDESTW-1:0] axis_m_tdest,
    input  logic              axis_s_tvalid,
    output logic              axis_s_tready,
    input  logic [TDATAW-1:0] axis_s_tdata,
    input  logic              axis_s_tlast,
    input  logic [TDESTW-1:0] axis_s_tdest
);

    localparam int FW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam int XW = (NUM_DESTS > 1) ? $clog2(NUM_DESTS) : 1;
    localparam logic [FW-1:0] FLIT_LAST = FW'(PKT_LEN - 1);
    localparam logic [XW-1:0] DEST_LAST = XW'(NUM_DESTS - 1);
    localparam logic [15:0]   PKT_FINAL = 16'(NUM_PACKETS - 1);
    localparam logic [15:0]   RX_TARGET = 16'(EXPECT_RX);
    localparam logic [16:0]   RX_LEN    = 17'(PKT_LEN);

    state_t              state, state_nxt;
    logic                m_valid_q;
    logic                s_ready_q;
    logic [FW-1:0]       flit_idx;
    logic [XW-1:0]       dest_idx;
    logic [15:0]         rx_flit;
    logic [LFSR_DW-1:0]  lfsr_q;
    logic                run_start, tx_last, tx_fire, tx_final, rx_fire, rx_last_fire;
    logic [15:0]         rx_count_nxt;
    logic                unused_rx_payload;

    assign run_start    = start && (state == IDLE || state == DONE);
    assign tx_last      = (flit_idx == FLIT_LAST);
    assign tx_fire      = m_valid_q && axis_m_tready;
    assign tx_final     = tx_fire && tx_last && (tx_count == PKT_FINAL);
    assign rx_fire      = axis_s_tvalid && s_ready_q;
    assign rx_last_fire = rx_fire && axis_s_tlast;
    assign rx_count_nxt = (rx_last_fire && rx_count != 16'hFFFF) ? rx_count + 16'd1 : rx_count;

    lfsr_galois #(
        .DW      (LFSR_DW),
        .TAPS    (LFSR_TAPS),
        .RST_VAL (LFSR_DEFAULT)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (run_start),
        .seed  (LFSR_DEFAULT[LFSR_DW-1:0]),
        .step  (tx_fire),
        .q     (lfsr_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = SEND;
            // A receive TLAST landing with the final transmit beat still counts here.
            SEND:       if (tx_final) state_nxt = (rx_count_nxt >= RX_TARGET) ? DONE : WAIT_RX;
            WAIT_RX:    if (rx_count_nxt >= RX_TARGET) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b0;
            flit_idx  <= '0;
            dest_idx  <= '0;
            tx_count  <= '0;
            rx_count  <= '0;
            rx_err    <= 1'b0;
            rx_flit   <= '0;
        end else begin
            s_ready_q <= 1'b1;
            if (run_start) begin
                m_valid_q <= 1'b1;
                flit_idx  <= '0;
                dest_idx  <= '0;
                tx_count  <= '0;
                rx_count  <= '0;
                rx_err    <= 1'b0;
                rx_flit   <= '0;
            end else begin
                if (tx_fire) begin
                    flit_idx <= tx_last ? '0 : flit_idx + FW'(1);
                    if (tx_last) begin
                        dest_idx <= (dest_idx == DEST_LAST) ? '0 : dest_idx + XW'(1);
                        if (tx_count != 16'hFFFF) tx_count <= tx_count + 16'd1;
                    end
                    if (tx_final) m_valid_q <= 1'b0;
                end
                rx_count <= rx_count_nxt;
                if (rx_fire) begin
                    if (axis_s_tlast) begin
                        rx_flit <= '0;
                        if ({1'b0, rx_flit} + 17'd1 != RX_LEN) rx_err <= 1'b1;
                    end else if (rx_flit != 16'hFFFF) begin
                        rx_flit <= rx_flit + 16'd1;
                    end
                end
            end
        end
    end

    // Transmit fields are forced to zero whenever no beat is offered.
    assign axis_m_tvalid = m_valid_q;
    assign axis_m_tdata  = m_valid_q ? TDATAW'(lfsr_q) : '0;
    assign axis_m_tlast  = m_valid_q && tx_last;
    assign axis_m_tdest  = m_valid_q ? (TDESTW'(DEST_BASE) + TDESTW'(dest_idx)) : '0;
    assign axis_s_tready = s_ready_q;
    assign busy          = (state == SEND) || (state == WAIT_RX);
    assign done          = (state == DONE);

    assign unused_rx_payload = &{1'b0, axis_s_tdata, axis_s_tdest};

endmodule

// File: tb/tb_axis_traffic_gen.sv
// Scoreboard bench for axis_traffic_gen: transmit beats checked by a monitor,
// counters and FSM status checked by the directed stimulus sequence.
module tb_axis_traffic_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, rx_err;
    logic [15:0] tx_count, rx_count;
    logic        m_tvalid, m_tlast;
    logic        m_tready = 1'b0;
    logic [31:0] m_tdata;
    logic [3:0]  m_tdest;
    logic        s_tvalid, s_tready, s_tlast;
    logic [31:0] s_tdata;
    logic [3:0]  s_tdest;
    logic        loop = 1'b0;
    logic        inj_valid = 1'b0;
    logic        inj_last = 1'b0;

    assign s_tvalid = loop ? (m_tvalid && m_tready) : inj_valid;
    assign s_tlast  = loop ? m_tlast : inj_last;
    assign s_tdata  = loop ? m_tdata : 32'h0;
    assign s_tdest  = m_tdest;

    always #5 clk = ~clk;

    axis_traffic_gen dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .tx_count      (tx_count),
        .rx_count      (rx_count),
        .rx_err        (rx_err),
        .axis_m_tvalid (m_tvalid),
        .axis_m_tready (m_tready),
        .axis_m_tdata  (m_tdata),
        .axis_m_tlast  (m_tlast),
        .axis_m_tdest  (m_tdest),
        .axis_s_tvalid (s_tvalid),
        .axis_s_tready (s_tready),
        .axis_s_tdata  (s_tdata),
        .axis_s_tlast  (s_tlast),
        .axis_s_tdest  (s_tdest)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [3:0]  dest;
    } beat_t;

    beat_t       exp_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          beat_cnt = 0;
    logic [7:0]  got_data[0:63];
    logic [3:0]  got_dest[0:63];
    logic [7:0]  hand_data[0:7] = '{8'hA5, 8'hEA, 8'h75, 8'h82, 8'h41, 8'h98, 8'h4C, 8'h26};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_step(input logic [7:0] l);
        return l[0] ? ((l >> 1) ^ 8'hB8) : (l >> 1);
    endfunction

    // Expected transmit stream of one full run: 16 packets x 4 flits.
    task automatic push_run();
        logic [7:0] l;
        beat_t      b;
        l = 8'hA5;
        for (int i = 0; i < 64; i++) begin
            b.data = {24'h0, l};
            b.last = (i % 4 == 3);
            b.dest = 4'(1 + (i / 4) % 2);
            exp_q.push_back(b);
            l = model_step(l);
        end
    endtask

    // Monitor: pops on every accepted beat, checks hold stability under backpressure.
    logic        stall_prev = 1'b0;
    logic [31:0] held_data;
    logic        held_last;
    logic [3:0]  held_dest;

    always @(negedge clk) begin
        beat_t b;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", {31'h0, m_tvalid}, 32'h1);
                chk("hold_data", m_tdata, held_data);
                chk("hold_last", {31'h0, m_tlast}, {31'h0, held_last});
                chk("hold_dest", {28'h0, m_tdest}, {28'h0, held_dest});
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", m_tdata);
                end else begin
                    b = exp_q.pop_front();
                    chk("beat_data", m_tdata, b.data);
                    chk("beat_last", {31'h0, m_tlast}, {31'h0, b.last});
                    chk("beat_dest", {28'h0, m_tdest}, {28'h0, b.dest});
                end
                if (beat_cnt < 64) begin
                    got_data[beat_cnt] = m_tdata[7:0];
                    got_dest[beat_cnt] = m_tdest;
                end
                beat_cnt++;
            end
            stall_prev = m_tvalid && !m_tready;
            held_data  = m_tdata;
            held_last  = m_tlast;
            held_dest  = m_tdest;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic rx_pkt(input int len);
        for (int b = 0; b < len; b++) begin
            inj_valid = 1'b1;
            inj_last  = (b == len - 1);
            tick();
        end
        inj_valid = 1'b0;
        inj_last  = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tvalid"}, {31'h0, m_tvalid}, 32'h0);
        chk({tag, "_tdata"}, m_tdata, 32'h0);
        chk({tag, "_tlast"}, {31'h0, m_tlast}, 32'h0);
        chk({tag, "_tdest"}, {28'h0, m_tdest}, 32'h0);
        chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
        chk({tag, "_done"}, {31'h0, done}, 32'h0);
        chk({tag, "_tx_count"}, {16'h0, tx_count}, 32'h0);
        chk({tag, "_rx_count"}, {16'h0, rx_count}, 32'h0);
        chk({tag, "_rx_err"}, {31'h0, rx_err}, 32'h0);
        chk({tag, "_s_tready"}, {31'h0, s_tready}, 32'h0);
    endtask

    initial begin
        int base;
        int c;

        // Reset state
        #12;
        chk_all_zero("reset");
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1 chk("s_tready_pre_edge", {31'h0, s_tready}, 32'h0);
        tick();
        chk("s_tready_idle", {31'h0, s_tready}, 32'h1);
        chk("idle_busy", {31'h0, busy}, 32'h0);

        // Run A: backpressure, no loopback, then manual receive traffic
        m_tready = 1'b1;
        push_run();
        pulse_start();
        chk("a_first_valid", {31'h0, m_tvalid}, 32'h1);
        chk("a_first_data", m_tdata, 32'hA5);
        chk("a_busy", {31'h0, busy}, 32'h1);
        for (c = 0; c < 300; c++) begin
            m_tready = !((c >= 1 && c < 4) || c == 20 || c == 21);
            tick();
            if (!m_tvalid) break;
        end
        m_tready = 1'b1;
        chk("a_tx_finished", {31'h0, m_tvalid}, 32'h0);
        chk("a_beats", 32'(beat_cnt), 32'd64);
        chk("a_queue_empty", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 8; i++) begin
            chk("a_hand_data", {24'h0, got_data[i]}, {24'h0, hand_data[i]});
            chk("a_hand_dest", {28'h0, got_dest[i]}, 32'(1 + i / 4));
        end
        chk("a_tx_count", {16'h0, tx_count}, 32'd16);
        chk("a_wait_busy", {31'h0, busy}, 32'h1);
        chk("a_wait_done", {31'h0, done}, 32'h0);
        chk("a_rx_count0", {16'h0, rx_count}, 32'd0);

        for (int p = 0; p < 15; p++) rx_pkt(4);
        chk("a_rx_count15", {16'h0, rx_count}, 32'd15);
        chk("a_rx15_busy", {31'h0, busy}, 32'h1);
        chk("a_rx15_done", {31'h0, done}, 32'h0);
        chk("a_rx15_err", {31'h0, rx_err}, 32'h0);

        rx_pkt(3);
        chk("a_rx_count16", {16'h0, rx_count}, 32'd16);
        chk("a_short_err", {31'h0, rx_err}, 32'h1);
        chk("a_done", {31'h0, done}, 32'h1);
        chk("a_done_busy", {31'h0, busy}, 32'h0);

        rx_pkt(4);
        chk("a_err_sticky", {31'h0, rx_err}, 32'h1);
        chk("a_rx_count17", {16'h0, rx_count}, 32'd17);

        // Run B: loopback from DONE
        loop = 1'b1;
        base = beat_cnt;
        push_run();
        pulse_start();
        chk("b_tx_cleared", {16'h0, tx_count}, 32'd0);
        chk("b_rx_cleared", {16'h0, rx_count}, 32'd0);
        chk("b_err_cleared", {31'h0, rx_err}, 32'h0);
        chk("b_busy", {31'h0, busy}, 32'h1);
        for (c = 0; c < 300 && !done; c++) tick();
        chk("b_done", {31'h0, done}, 32'h1);
        chk("b_busy_low", {31'h0, busy}, 32'h0);
        chk("b_tx_count", {16'h0, tx_count}, 32'd16);
        chk("b_rx_count", {16'h0, rx_count}, 32'd16);
        chk("b_rx_err", {31'h0, rx_err}, 32'h0);
        chk("b_beats", 32'(beat_cnt - base), 32'd64);
        chk("b_tvalid_low", {31'h0, m_tvalid}, 32'h0);

        // Run C: reset mid-packet, then a clean restart
        loop = 1'b0;
        push_run();
        pulse_start();
        for (int i = 0; i < 6; i++) tick();
        chk("c_mid_packet", {31'h0, m_tvalid}, 32'h1);
        #1 rst_n = 1'b0;
        exp_q.delete();
        #1 chk_all_zero("c_reset");
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        chk("c_s_tready", {31'h0, s_tready}, 32'h1);
        loop = 1'b1;
        base = beat_cnt;
        push_run();
        pulse_start();
        chk("c_restart_data", m_tdata, 32'hA5);
        chk("c_restart_tx", {16'h0, tx_count}, 32'd0);
        for (c = 0; c < 300 && !done; c++) tick();
        chk("c_done", {31'h0, done}, 32'h1);
        chk("c_tx_count", {16'h0, tx_count}, 32'd16);
        chk("c_rx_count", {16'h0, rx_count}, 32'd16);
        chk("c_beats", 32'(beat_cnt - base), 32'd64);
        chk("c_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
